fa4_serial: RTL and testbench
=============================

FA4_SERIAL -- requirements
Module: fa4_serial

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand a; sampled on the accepting edge only.
REQ-006 Port: b  input  WIDTH  operand b; sampled on the accepting edge only.
REQ-007 Port: ci  input  1  carry in; sampled on the accepting edge only.
REQ-008 Port: sub  input  1  subtract request; present only when FA4_SERIAL_SUB_EN is defined.
REQ-009 Port: busy  output  1  high in RUN and DONE.
REQ-010 Port: done  output  1  one-cycle completion pulse; high in DONE only.
REQ-011 Port: s  output  WIDTH  registered sum; holds the last completed result.
REQ-012 Port: co  output  1  registered carry out; holds the last completed result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE->RUN on a rising edge with start=1: latch a and b into shift registers, load the carry register from ci, and clear the bit counter.
REQ-015 In RUN, each edge SHALL add one bit position LSB-first (a_sh[0], b_sh[0], carry), using full-adder equations: sum = a^b^c, carry = ab|bc|ac.
REQ-016 In RUN, each edge SHALL shift the sum bit into the MSB of the result shift register, shift both operand registers right by one, and increment the counter.
REQ-017 On the edge that processes bit WIDTH-1, the FSM SHALL go RUN->DONE and load s from the completed result register and co from the final carry.
REQ-018 DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-019 Latency: done SHALL be high exactly WIDTH cycles after the edge that sampled start, for exactly one cycle.
REQ-020 Result: {co,s} SHALL equal a+b+ci modulo 2^(WIDTH+1) for every operand combination.
REQ-021 start SHALL be ignored in RUN and DONE; the operation in flight SHALL be unaffected by changes on start, a, b, ci and sub.
REQ-022 start held high continuously SHALL begin a new operation on the first edge in IDLE, giving back-to-back operations every WIDTH+2 cycles.
REQ-023 s and co SHALL change only on the RUN->DONE edge or on reset.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits and SHALL NOT wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL force the following immediately, without waiting for clk: state=IDLE, busy=0, done=0, s=0, co=0, and all shift, carry and counter registers=0.
REQ-026 A reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow and s/co SHALL read 0.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 The macro FA4_SERIAL_SUB_EN SHALL compile the subtract feature in or out.
REQ-029 With FA4_SERIAL_SUB_EN defined and sub=1 on the accepting edge, the block SHALL latch ~b and set the carry register to 1 (ci ignored), so that s=a-b mod 2^WIDTH and co=1 means no borrow.
REQ-030 With FA4_SERIAL_SUB_EN defined and sub=0, the block SHALL behave exactly as the add-only build.
REQ-031 Without FA4_SERIAL_SUB_EN, the sub port and its logic SHALL be absent and the block SHALL be add-only.

Verification (WIDTH=4)
REQ-032 Basic add: start with a=5, b=3, ci=0 -> done exactly 4 cycles later, s=8, co=0, busy high for 5 cycles.
REQ-033 Overflow: a=F, b=1, ci=1 -> s=1, co=1; then all 512 {a,b,ci} combinations back-to-back -> each {co,s} matches a+b+ci, and the done spacing is 6 cycles.
REQ-034 Busy lockout: start with a=2, b=2; pulse start with a=F, b=F during RUN -> single done, s=4, co=0.
REQ-035 Reset abort: start with a=7, b=7; assert rst_n=0 two cycles later -> busy, done, s and co all 0 immediately with no further done; next start with a=1, b=1 -> s=2.
REQ-036 Subtract (FA4_SERIAL_SUB_EN defined): a=5, b=3, sub=1 -> s=2, co=1; a=3, b=5, sub=1 -> s=E, co=0.

Source files
------------

// File: rtl/fa4_serial.sv
// fa4_serial: bit-serial ripple adder, LSB-first, one bit per clock.
// Define FA4_SERIAL_SUB_EN to add the sub port (a-b via ~b and carry-in 1).
module fa4_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef FA4_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, b_ld;
  logic [CW-1:0] cnt;
  logic c, c_ld, sum_bit, c_nx, last;
`ifdef FA4_SERIAL_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | ci;
`else
  assign b_ld = b;
  assign c_ld = ci;
`endif
  assign sum_bit = a_sh[0] ^ b_sh[0] ^ c;
  assign c_nx = (a_sh[0] & b_sh[0]) | (b_sh[0] & c) | (a_sh[0] & c);
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      s <= '0;
      co <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b_ld;
        c <= c_ld;
        cnt <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= {sum_bit, r_sh[WIDTH-1:1]};
        c <= c_nx;
        // hold the counter on the final bit so it never wraps mid-operation
        cnt <= last ? cnt : cnt + 1'b1;
        if (last) begin
          s <= {sum_bit, r_sh[WIDTH-1:1]};
          co <= c_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_fa4_serial.sv
// tb_fa4_serial: directed checks of the serial adder at WIDTH=4.
module tb_fa4_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic ci = 1'b0;
`ifdef FA4_SERIAL_SUB_EN
  logic sub = 1'b0;
`endif
  logic busy, done, co;
  logic [3:0] s;
  int total = 0, bad = 0;
  int cyc = 0;
  fa4_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
`ifdef FA4_SERIAL_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .co(co)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [3:0] aa, input logic [3:0] bb, input logic cc, output int lat);
    a = aa; b = bb; ci = cc; start = 1'b1;
    tick();
    start = 1'b0; a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    if (!done) lat = 99;
  endtask
  initial begin
    int lat, nb, nd, last_cyc;
    logic [4:0] got, exp5;
    logic [3:0] s_mid;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL rst_busy: got %0h", busy); end
    total++; if (done !== 1'b0) begin bad++; $error("FAIL rst_done: got %0h", done); end
    total++; if (s !== 4'h0) begin bad++; $error("FAIL rst_s: got %0h", s); end
    total++; if (co !== 1'b0) begin bad++; $error("FAIL rst_co: got %0h", co); end
    tick();
    rst_n = 1'b1;
    tick();
    a = 4'h5; b = 4'h3; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 4'hA; b = 4'hC; ci = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $error("FAIL add_busy_accept: got %0h", busy); end
    total++; if (done !== 1'b0) begin bad++; $error("FAIL add_done_accept: got %0h", done); end
    nb = 1; nd = 0; lat = 0; got = '0; s_mid = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (busy) nb++;
      if (k == 3) s_mid = s;
      if (done) begin
        nd++;
        if (lat == 0) lat = k;
        got = {co, s};
      end
    end
    total++; if (lat !== 4) begin bad++; $error("FAIL add_latency: got %0d", lat); end
    total++; if (nb !== 5) begin bad++; $error("FAIL add_busy_cycles: got %0d", nb); end
    total++; if (nd !== 1) begin bad++; $error("FAIL add_done_count: got %0d", nd); end
    total++; if (got !== 5'h08) begin bad++; $error("FAIL add_result: got %0h", got); end
    total++; if (s_mid !== 4'h0) begin bad++; $error("FAIL add_s_hold_mid: got %0h", s_mid); end
    do_op(4'hF, 4'h1, 1'b1, lat);
    got = {co, s};
    total++; if (lat !== 4) begin bad++; $error("FAIL ovf_latency: got %0d", lat); end
    total++; if (got !== 5'h11) begin bad++; $error("FAIL ovf_result: got %0h", got); end
    tick();
    tick();
    start = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      a = v[8:5]; b = v[4:1]; ci = v[0];
      exp5 = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
      tick();
      total++; if (busy !== 1'b1) begin bad++; $error("FAIL b2b_accept %0d: got %0h", i, busy); end
      a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
      lat = 0;
      while (!done && lat < 20) begin
        tick();
        lat++;
      end
      total++; if (lat !== 4) begin bad++; $error("FAIL b2b_latency %0d: got %0d", i, lat); end
      got = {co, s};
      total++; if (got !== exp5) begin bad++; $error("FAIL b2b_result %0d: got %0h expected %0h", i, got, exp5); end
      if (i > 0) begin
        total++; if (cyc - last_cyc !== 6) begin bad++; $error("FAIL b2b_spacing %0d: got %0d", i, cyc - last_cyc); end
      end
      last_cyc = cyc;
      tick();
      total++; if (busy !== 1'b0) begin bad++; $error("FAIL b2b_idle %0d: got %0h", i, busy); end
    end
    start = 1'b0;
    tick();
    a = 4'h2; b = 4'h2; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 4'hF; b = 4'hF; ci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0; got = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) begin
        nd++;
        got = {co, s};
      end
    end
    total++; if (nd !== 1) begin bad++; $error("FAIL lock_done_count: got %0d", nd); end
    total++; if (got !== 5'h04) begin bad++; $error("FAIL lock_result: got %0h", got); end
    a = 4'h7; b = 4'h7; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $error("FAIL abort_busy_before: got %0h", busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL abort_busy: got %0h", busy); end
    total++; if (done !== 1'b0) begin bad++; $error("FAIL abort_done: got %0h", done); end
    total++; if (s !== 4'h0) begin bad++; $error("FAIL abort_s: got %0h", s); end
    total++; if (co !== 1'b0) begin bad++; $error("FAIL abort_co: got %0h", co); end
    tick();
    #2 rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) nd++;
    end
    total++; if (nd !== 0) begin bad++; $error("FAIL abort_no_done: got %0d", nd); end
    total++; if (s !== 4'h0) begin bad++; $error("FAIL abort_s_after: got %0h", s); end
    do_op(4'h1, 4'h1, 1'b0, lat);
    got = {co, s};
    total++; if (lat !== 4) begin bad++; $error("FAIL post_rst_latency: got %0d", lat); end
    total++; if (got !== 5'h02) begin bad++; $error("FAIL post_rst_result: got %0h", got); end
    tick();
`ifdef FA4_SERIAL_SUB_EN
    sub = 1'b1;
    do_op(4'h5, 4'h3, 1'b0, lat);
    got = {co, s};
    total++; if (got !== 5'h12) begin bad++; $error("FAIL sub_5_3: got %0h", got); end
    tick();
    do_op(4'h3, 4'h5, 1'b1, lat);
    got = {co, s};
    total++; if (got !== 5'h0E) begin bad++; $error("FAIL sub_3_5: got %0h", got); end
    tick();
    sub = 1'b0;
    do_op(4'h3, 4'h5, 1'b1, lat);
    got = {co, s};
    total++; if (got !== 5'h09) begin bad++; $error("FAIL sub_off_add: got %0h", got); end
    tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
